// File: rtl/count_mon_pkg.sv
// -----------------------------------------------------------------------------
// count_mon_pkg
// Shared types for the count wrap monitor.
//   mon_state_t : monitor FSM states (IDLE, TRACK, ERROR)
//   step_kind_t : classification of one sampled count against the previous one
//                 (HOLD, STEP, WRAP, BAD)
// -----------------------------------------------------------------------------
package count_mon_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      TRACK = 2'd1,
      ERROR = 2'd2
   } mon_state_t;

   typedef enum logic [1:0] {
      HOLD = 2'd0,
      STEP = 2'd1,
      WRAP = 2'd2,
      BAD  = 2'd3
   } step_kind_t;

endpackage

// File: rtl/count_step_check.sv
// -----------------------------------------------------------------------------
// count_step_check
// Purely combinational classifier: decides whether `count` is a legal single
// step from `prev` in the direction `dir_q`.
// Ports:
//   prev  [SIZE-1:0] in  last sampled count
//   count [SIZE-1:0] in  newly sampled count
//   dir_q            in  direction that was live when prev was captured (1 = up)
//   kind             out HOLD / STEP / WRAP / BAD
// -----------------------------------------------------------------------------
module count_step_check
   import count_mon_pkg::*;
#(
   parameter int SIZE = 4
) (
   input  logic [SIZE-1:0] prev,
   input  logic [SIZE-1:0] count,
   input  logic            dir_q,
   output step_kind_t      kind
);

   logic [SIZE-1:0] expect_next;
   logic [SIZE-1:0] wrap_from;

   always_comb begin
      // Natural SIZE-bit truncation gives the modular step.
      expect_next = dir_q ? (prev + SIZE'(1)) : (prev - SIZE'(1));
      // The only value from which a legal step in this direction wraps.
      wrap_from   = dir_q ? {SIZE{1'b1}} : {SIZE{1'b0}};

      kind = BAD;
      if (count == prev) begin
         kind = HOLD;
      end else if (count == expect_next) begin
         kind = (prev == wrap_from) ? WRAP : STEP;
      end
   end

endmodule

// File: rtl/count_wrap_monitor.sv
// -----------------------------------------------------------------------------
// count_wrap_monitor
// Samples a counter's output every clock, checks that each new value is a hold
// or a single step in the registered direction, pulses on every wrap, keeps a
// wrap tally and raises a sticky error on any illegal jump.
// Ports:
//   clk                     in  clock shared with the counter
//   rst                     in  asynchronous active-low reset shared with the counter
//   up                      in  direction control, same net as the counter's
//   count      [SIZE-1:0]   in  counter output being monitored
//   clr                     in  synchronous clear of tally, flags and FSM
//   wrap_pulse              out one-cycle pulse per detected wrap
//   wrap_count [WRAP_W-1:0] out wraps seen, modulo 2^WRAP_W
//   wrap_ovf                out sticky, set when wrap_count rolls over
//   step_err                out sticky, set on an illegal step
//   tracking                out high while in TRACK
// -----------------------------------------------------------------------------
module count_wrap_monitor
   import count_mon_pkg::*;
#(
   parameter int SIZE   = 4,
   parameter int WRAP_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              up,
   input  logic [SIZE-1:0]   count,
   input  logic              clr,
   output logic              wrap_pulse,
   output logic [WRAP_W-1:0] wrap_count,
   output logic              wrap_ovf,
   output logic              step_err,
   output logic              tracking
);

   mon_state_t        state_reg,      state_next;
   logic [SIZE-1:0]   prev_reg,       prev_next;
   logic              dir_q_reg,      dir_q_next;
   logic              wrap_pulse_reg, wrap_pulse_next;
   logic [WRAP_W-1:0] wrap_count_reg, wrap_count_next;
   logic              wrap_ovf_reg,   wrap_ovf_next;
   logic              step_err_reg,   step_err_next;
   logic              tracking_reg,   tracking_next;

   step_kind_t        kind;

   // The counter's value at this edge reflects `up` from the previous edge,
   // so the check uses the registered direction, never the live one.
   count_step_check #(
      .SIZE (SIZE)
   ) u_step_check (
      .prev  (prev_reg),
      .count (count),
      .dir_q (dir_q_reg),
      .kind  (kind)
   );

   always_comb begin
      state_next      = state_reg;
      prev_next       = prev_reg;
      dir_q_next      = dir_q_reg;
      wrap_pulse_next = 1'b0;
      wrap_count_next = wrap_count_reg;
      wrap_ovf_next   = wrap_ovf_reg;
      step_err_next   = step_err_reg;

      if (clr) begin
         // clr overrides anything sampled this cycle, including a wrap.
         state_next      = IDLE;
         wrap_count_next = '0;
         wrap_ovf_next   = 1'b0;
         step_err_next   = 1'b0;
      end else begin
         unique case (state_reg)
            IDLE: begin
               prev_next  = count;
               dir_q_next = up;
               state_next = TRACK;
            end
            TRACK: begin
               prev_next  = count;
               dir_q_next = up;
               unique case (kind)
                  WRAP: begin
                     wrap_pulse_next = 1'b1;
                     wrap_count_next = wrap_count_reg + WRAP_W'(1);
                     if (wrap_count_reg == {WRAP_W{1'b1}}) begin
                        wrap_ovf_next = 1'b1;
                     end
                  end
                  BAD: begin
                     step_err_next = 1'b1;
                     state_next    = ERROR;
                  end
                  default: begin
                  end
               endcase
            end
            ERROR: begin
               // Everything frozen until clr or rst.
            end
            default: begin
               state_next = IDLE;
            end
         endcase
      end

      tracking_next = (state_next == TRACK);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg      <= IDLE;
         prev_reg       <= '0;
         dir_q_reg      <= 1'b0;
         wrap_pulse_reg <= 1'b0;
         wrap_count_reg <= '0;
         wrap_ovf_reg   <= 1'b0;
         step_err_reg   <= 1'b0;
         tracking_reg   <= 1'b0;
      end else begin
         state_reg      <= state_next;
         prev_reg       <= prev_next;
         dir_q_reg      <= dir_q_next;
         wrap_pulse_reg <= wrap_pulse_next;
         wrap_count_reg <= wrap_count_next;
         wrap_ovf_reg   <= wrap_ovf_next;
         step_err_reg   <= step_err_next;
         tracking_reg   <= tracking_next;
      end
   end

   assign wrap_pulse = wrap_pulse_reg;
   assign wrap_count = wrap_count_reg;
   assign wrap_ovf   = wrap_ovf_reg;
   assign step_err   = step_err_reg;
   assign tracking   = tracking_reg;

endmodule

// File: tb/tb_count_wrap_monitor.sv
// -----------------------------------------------------------------------------
// tb_count_wrap_monitor
// Drives count/up/clr/rst on the falling edge, emulating the counter (its value
// at an edge reflects `up` from the previous edge). A reference model computes
// the expected outputs after every rising edge and queues them; a monitor pops
// one expectation per rising edge and compares all outputs.
// -----------------------------------------------------------------------------
module tb_count_wrap_monitor;

   localparam int SIZE   = 4;
   localparam int WRAP_W = 8;
   localparam int MOD    = 1 << SIZE;
   localparam int WMOD   = 1 << WRAP_W;

   logic              clk = 1'b0;
   logic              rst;
   logic              up;
   logic [SIZE-1:0]   count;
   logic              clr;
   logic              wrap_pulse;
   logic [WRAP_W-1:0] wrap_count;
   logic              wrap_ovf;
   logic              step_err;
   logic              tracking;

   always #5 clk = ~clk;

   count_wrap_monitor #(
      .SIZE   (SIZE),
      .WRAP_W (WRAP_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .up         (up),
      .count      (count),
      .clr        (clr),
      .wrap_pulse (wrap_pulse),
      .wrap_count (wrap_count),
      .wrap_ovf   (wrap_ovf),
      .step_err   (step_err),
      .tracking   (tracking)
   );

   typedef struct packed {
      logic              pulse;
      logic [WRAP_W-1:0] wc;
      logic              ovf;
      logic              err;
      logic              trk;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;
   int   txn    = 0;

   // Reference model state: 0 = waiting for first sample, 1 = checking, 2 = stuck.
   int m_mode, m_prev, m_dir, m_wc, m_ovf, m_err, m_pulse, m_trk;
   int cnt_val;

   task automatic model_step(input logic r, input logic c, input logic u, input int v);
      int diff;
      m_pulse = 0;
      if (!r) begin
         m_mode = 0; m_prev = 0; m_dir = 0;
         m_wc = 0; m_ovf = 0; m_err = 0; m_trk = 0;
      end else if (c) begin
         m_mode = 0; m_wc = 0; m_ovf = 0; m_err = 0; m_trk = 0;
      end else if (m_mode == 0) begin
         m_prev = v; m_dir = int'(u); m_mode = 1; m_trk = 1;
      end else if (m_mode == 1) begin
         diff = (v - m_prev + MOD) % MOD;
         if (diff == 0) begin
            // hold
         end else if (diff == (m_dir != 0 ? 1 : MOD - 1)) begin
            if ((m_dir != 0 && m_prev == MOD - 1 && v == 0) ||
                (m_dir == 0 && m_prev == 0 && v == MOD - 1)) begin
               m_pulse = 1;
               m_wc    = (m_wc + 1) % WMOD;
               if (m_wc == 0) m_ovf = 1;
            end
         end else begin
            m_err  = 1;
            m_mode = 2;
            m_trk  = 0;
         end
         m_prev = v;
         m_dir  = int'(u);
      end
   endtask

   task automatic cyc(input logic r, input logic c, input logic u, input int v);
      exp_t e;
      @(negedge clk);
      rst   = r;
      clr   = c;
      up    = u;
      count = v[SIZE-1:0];
      model_step(r, c, u, v);
      e.pulse = m_pulse[0];
      e.wc    = m_wc[WRAP_W-1:0];
      e.ovf   = m_ovf[0];
      e.err   = m_err[0];
      e.trk   = m_trk[0];
      exp_q.push_back(e);
   endtask

   function automatic int next_cnt(input int c, input logic u);
      return (c + (u ? 1 : MOD - 1)) % MOD;
   endfunction

   // Free-running counter for n cycles in direction u.
   task automatic run(input int n, input logic u);
      for (int i = 0; i < n; i++) begin
         cyc(1'b1, 1'b0, u, cnt_val);
         cnt_val = next_cnt(cnt_val, u);
      end
   endtask

   task automatic clr_cycle(input logic u);
      cyc(1'b1, 1'b1, u, cnt_val);
      cnt_val = next_cnt(cnt_val, u);
   endtask

   task automatic rst_cycle(input logic u);
      cyc(1'b0, 1'b0, u, 0);
      cnt_val = 0;
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (txn %0d, t=%0t)", nm, act, exp, txn, $time);
      end
   endtask

   // Monitor: one expectation per rising edge, sampled 1 time unit later.
   always @(posedge clk) begin : monitor
      exp_t e;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         txn++;
         $display("txn %0d: pulse=%0b wrap_count=%0d ovf=%0b err=%0b tracking=%0b",
                  txn, wrap_pulse, wrap_count, wrap_ovf, step_err, tracking);
         chk("wrap_pulse", int'(wrap_pulse), int'(e.pulse));
         chk("wrap_count", int'(wrap_count), int'(e.wc));
         chk("wrap_ovf",   int'(wrap_ovf),   int'(e.ovf));
         chk("step_err",   int'(step_err),   int'(e.err));
         chk("tracking",   int'(tracking),   int'(e.trk));
      end
   end

   initial begin
      logic u;
      int   r;
      int   v;
      rst = 1'b0; clr = 1'b0; up = 1'b0; count = '0;
      cnt_val = 0;
      m_mode = 0; m_prev = 0; m_dir = 0; m_wc = 0;
      m_ovf = 0; m_err = 0; m_pulse = 0; m_trk = 0;

      // 1: reset, then free-running up for 40 cycles (two 15->0 wraps).
      rst_cycle(1'b1);
      rst_cycle(1'b1);
      run(40, 1'b1);

      // 2: shared reset mid-count, then count down through 0->15.
      run(5, 1'b1);
      rst_cycle(1'b0);
      run(20, 1'b0);

      // 3: illegal jump 5->9 while going up; later wraps ignored; clr recovers.
      clr_cycle(1'b1);
      while (cnt_val != 5) run(1, 1'b1);
      run(1, 1'b1);
      cyc(1'b1, 1'b0, 1'b1, 9);
      cnt_val = 10;
      run(40, 1'b1);
      clr_cycle(1'b1);
      run(3, 1'b1);

      // 4: direction toggle at 7: 7->8 seen, then 8->7.
      while (cnt_val != 7) run(1, 1'b1);
      run(1, 1'b1);
      run(1, 1'b0);
      run(6, 1'b0);
      run(5, 1'b1);

      // 5: enough up-wraps to roll the tally over.
      clr_cycle(1'b1);
      run(256 * MOD + 20, 1'b1);

      // 6: clr in the same cycle as a 15->0 sample.
      while (cnt_val != MOD - 1) run(1, 1'b1);
      run(1, 1'b1);
      cyc(1'b1, 1'b1, 1'b1, 0);
      cnt_val = 1;
      run(5, 1'b1);

      // Randomized mix: holds, direction changes, jumps, clears, resets.
      u = 1'b1;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 99) < 10) u = ~u;
         r = int'($urandom_range(0, 99));
         if (r < 2) begin
            rst_cycle(u);
         end else if (r < 5) begin
            clr_cycle(u);
         end else if (r < 8) begin
            v = int'($urandom_range(0, MOD - 1));
            cyc(1'b1, 1'b0, u, v);
            cnt_val = next_cnt(v, u);
         end else if (r < 20) begin
            cyc(1'b1, 1'b0, u, cnt_val);
         end else begin
            run(1, u);
         end
      end

      repeat (3) @(negedge clk);
      chk("queue_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
